// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared state type and requester indices for the LC-3 memory arbiter
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way combinational winner picker
// Ports:
//   req[1:0]     in   request bits, [0]=CPU [1]=DMA
//   last_winner  in   index of the previous winner
//   win_valid    out  at least one request present
//   win_idx      out  index of the chosen requester
// Config: MEM_ARB_FIXED_PRIO_EN selects fixed CPU priority on a tie.
module arb_rr2
  import lc3_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       win_valid,
  output logic       win_idx
);

  always_comb begin
    win_valid = |req;
    win_idx   = REQ_CPU;
    if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win_idx = REQ_CPU;
`else
      // Tie goes to whoever did not win last time.
      win_idx = ~last_winner;
`endif
    end else if (req[REQ_DMA]) begin
      win_idx = REQ_DMA;
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - shares one LC-3 memory port between the CPU and a DMA/debug loader
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req/req_we[1:0]     per-requester request and write flag, [0]=CPU [1]=DMA
//   req_addr/req_wdata  packed per-requester address/data, requester 1 in the upper half
//   gnt/done[1:0]       one-cycle grant and completion pulses
//   rdata               read data, valid with done after a read
//   mem_en/mem_we       memory strobe and write enable
//   mem_addr/mem_wdata  latched address and write data
//   mem_rdata           memory read data
// Config: MEM_ARB_FIXED_PRIO_EN (inside arb_rr2) gives the CPU fixed priority.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int              LCW    = $clog2(MEM_LAT + 1);
  localparam logic [LCW-1:0]  LAT_M1 = LCW'(MEM_LAT - 1);
  localparam logic [LCW-1:0]  LAT_1  = LCW'(1);

  arb_state_t      state_q, state_d;
  logic            last_winner_q, last_winner_d;
  logic [1:0]      gnt_q, gnt_d, done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;

  logic win_valid, win_idx;

  arb_rr2 u_pick (
    .req         (req),
    .last_winner (last_winner_q),
    .win_valid   (win_valid),
    .win_idx     (win_idx)
  );

  // last_winner_q doubles as the index of the transaction in flight.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    gnt_d         = 2'b00;
    done_d        = 2'b00;
    rdata_d       = rdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    lat_cnt_d     = lat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          last_winner_d   = win_idx;
          gnt_d[win_idx]  = 1'b1;
          mem_en_d        = 1'b1;
          mem_we_d        = req_we[win_idx];
          mem_addr_d      = win_idx ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
          mem_wdata_d     = win_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        // mem_we_q still holds the latched write flag during ACCESS.
        if (mem_we_q) begin
          done_d[last_winner_q] = 1'b1;
          state_d               = RESP;
        end else begin
          lat_cnt_d = LAT_M1;
          if (MEM_LAT == 1) begin
            rdata_d               = mem_rdata;
            done_d[last_winner_q] = 1'b1;
            state_d               = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_1;
        if (lat_cnt_q == LAT_1) begin
          rdata_d               = mem_rdata;
          done_d[last_winner_q] = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_winner_q <= REQ_DMA;
      gnt_q         <= 2'b00;
      done_q        <= 2'b00;
      rdata_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
